// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, one-cycle press/release pulses.
// Optional long-press pulse is built only when the BTN_LONG_PRESS_EN macro is defined.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
            $error("button_debouncer: illegal DEBOUNCE_CYCLES / LONG_PRESS_CYCLES combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    logic             pressed_raw;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             btn_level_q, btn_level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Polarity is normalised before synchronizing so reset value 0 always means "not pressed".
    assign pressed_raw = btn_in ^ ACTIVE_LOW;

    always_comb begin
        s0_d = pressed_raw;
        s1_d = s0_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= 1'b0;
            s1_q <= 1'b0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    // Saturating increment: the count can never wrap back into an accept.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        btn_level_d = btn_level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                btn_level_d = 1'b0;
                if (s1_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s1_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d     = ST_PRESSED;
                    cnt_d       = '0;
                    btn_level_d = 1'b1;
                    press_d     = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PRESSED: begin
                btn_level_d = 1'b1;
                if (!s1_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s1_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    btn_level_d = 1'b0;
                    release_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                btn_level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [31:0] HOLD_TARGET = 32'(LONG_PRESS_CYCLES);

    logic [31:0] hold_q, hold_d;
    logic        long_q, long_d;
    logic        hold_clr;

    assign hold_clr = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);

    // Hold counter stops at the target, so the pulse fires at most once per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (hold_clr) begin
            hold_d = '0;
        end else if ((state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) &&
                     (hold_q != HOLD_TARGET)) begin
            hold_d = hold_q + 32'd1;
            long_d = (hold_d == HOLD_TARGET);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer against a sample-history reference model.
module tb_button_debouncer;

    localparam int D  = 4;
    localparam int L  = 20;
    localparam bit AL = 1'b1;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level, press_pulse, release_pulse, long_pulse;
    logic [3:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_s0, m_s1;
    bit         hist[$];
    bit         m_level;
    int         m_hold;
    logic [3:0] exp_vec;

    button_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .LONG_PRESS_CYCLES(L),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    assign obs = {btn_level, press_pulse, release_pulse, long_pulse};

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    task automatic model_reset;
        m_s0 = 1'b0;
        m_s1 = 1'b0;
        hist.delete();
        m_level = 1'b0;
        m_hold  = 0;
        exp_vec = 4'b0000;
    endtask

    // Drive one raw sample, advance one clock, update the model, settle 1 time unit past the edge.
    // The level flips once the last D samples seen by the debouncer all disagree with it.
    task automatic step(input bit b);
        bit fsm_in, prev, all_opp, e_long;
        btn_in = b;
        @(posedge clk);
        fsm_in = m_s1;
        m_s1   = m_s0;
        m_s0   = b ^ AL;
        hist.push_back(fsm_in);
        if (hist.size() > D) void'(hist.pop_front());
        prev    = m_level;
        all_opp = (hist.size() == D);
        foreach (hist[i]) if (hist[i] == prev) all_opp = 1'b0;
        if (all_opp) m_level = !prev;
        e_long = 1'b0;
        if (!prev && m_level) begin
            m_hold = 0;
        end else if (prev && m_hold < L) begin
            m_hold++;
            e_long = (m_hold == L) && LONG_EN;
        end
        exp_vec = {m_level, (!prev && m_level), (prev && !m_level), e_long};
        #1;
    endtask

    task automatic test_reset;
        int press_at;
        rst = 1'b1;
        btn_in = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %b want 0000", i, obs);
            end
            checks++;
        end
        rst = 1'b0;
        press_at = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL reset_release cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
            if (press_pulse && press_at < 0) press_at = i;
        end
        if (press_at != 6 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL reset_requalify press_at %0d want 6 level %b want 1", press_at, btn_level);
        end
        checks++;
    endtask

    task automatic test_clean;
        int press_at, rel_at, npress, nrel;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL clean_settle cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
        end
        press_at = -1; npress = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL clean_press cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
            if (press_pulse) begin npress++; if (press_at < 0) press_at = i; end
        end
        if (press_at != 6 || npress != 1 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL clean_press_timing at %0d n %0d want 6/1 level %b", press_at, npress, btn_level);
        end
        checks++;
        rel_at = -1; nrel = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL clean_release cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
            if (release_pulse) begin nrel++; if (rel_at < 0) rel_at = i; end
        end
        if (rel_at != 6 || nrel != 1 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL clean_release_timing at %0d n %0d want 6/1 level %b", rel_at, nrel, btn_level);
        end
        checks++;
    endtask

    task automatic test_chatter;
        int npulse;
        bit level_seen;
        npulse = 0; level_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step((i < 40) ? bit'((i / 2) % 2) : 1'b1);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL chatter cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
            npulse += int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
            if (btn_level) level_seen = 1'b1;
        end
        if (npulse != 0 || level_seen) begin
            errors++;
            $display("FAIL chatter_quiet pulses %0d want 0 level_seen %b want 0", npulse, level_seen);
        end
        checks++;
    endtask

    task automatic test_release_glitch;
        int nrel;
        bit dropped;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL glitch_press cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
        end
        nrel = 0; dropped = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step((i < 3) ? 1'b1 : 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL glitch cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
            if (release_pulse) nrel++;
            if (!btn_level) dropped = 1'b1;
        end
        if (nrel != 0 || dropped) begin
            errors++;
            $display("FAIL glitch_hold releases %0d want 0 dropped %b want 0", nrel, dropped);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL glitch_release cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_long_press;
        int press_at, long_at, nlong, nlong_rel, nrel;
        press_at = -1;
        for (int i = 1; i <= 20 && press_at < 0; i++) begin
            step(1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL long_qualify cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
            if (press_pulse) press_at = i;
        end
        if (press_at < 0) begin
            errors++;
            $display("FAIL long_no_press got none want press within 20 cycles");
        end
        checks++;
        long_at = -1; nlong = 0;
        for (int j = 1; j <= 40; j++) begin
            step(1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL long_hold cyc %0d got %b want %b", j, obs, exp_vec);
            end
            checks++;
            if (long_pulse) begin nlong++; if (long_at < 0) long_at = j; end
        end
        if (LONG_EN ? (nlong != 1 || long_at != L) : (nlong != 0)) begin
            errors++;
            $display("FAIL long_timing count %0d at %0d want count %0d at %0d",
                     nlong, long_at, LONG_EN ? 1 : 0, LONG_EN ? L : -1);
        end
        checks++;
        nlong_rel = 0; nrel = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL long_release cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
            if (long_pulse) nlong_rel++;
            if (release_pulse) nrel++;
        end
        if (nrel != 1 || nlong_rel != 0) begin
            errors++;
            $display("FAIL long_after_release releases %0d want 1 longs %0d want 0", nrel, nlong_rel);
        end
        checks++;
    endtask

    task automatic test_reset_mid;
        int press_at;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL mid_wait cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
        end
        rst = 1'b1;
        #1;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL mid_async_wait got %b want 0000", obs);
        end
        checks++;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL mid_requal cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
        end
        // Reset lands on the very cycle press_pulse is high.
        rst = 1'b1;
        #1;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL mid_async_pulse got %b want 0000", obs);
        end
        checks++;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        press_at = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL mid_requal2 cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
            if (press_pulse && press_at < 0) press_at = i;
        end
        if (press_at != 6) begin
            errors++;
            $display("FAIL mid_fresh_qual press_at %0d want 6", press_at);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL mid_release cyc %0d got %b want %b", i, obs, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_random;
        int  n;
        int  len;
        bit  val;
        n = 0;
        while (n < 800) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(posedge clk); #1;
                if (obs !== 4'b0000) begin
                    errors++;
                    $display("FAIL random_reset at %0d got %b want 0000", n, obs);
                end
                checks++;
                model_reset();
                rst = 1'b0;
            end
            val = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(20, 40))
                                                 : int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                step(val);
                if (obs !== exp_vec) begin
                    errors++;
                    $display("FAIL random cyc %0d got %b want %b", n, obs, exp_vec);
                end
                checks++;
                n++;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b1;
        model_reset();
        test_reset();
        test_clean();
        test_chatter();
        test_release_glitch();
        test_long_press();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
